wb_initiator: RTL

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_initiator_if.sv | 49 ++++
 rtl/wb_watchdog.sv | 29 ++
 rtl/wb_initiator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: initiator FSM states, bus widths and the
// handshake/register-map constants common to the initiator and its responder.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int CNT_W     = 16;
  localparam int WDOG_W    = 16;

  localparam logic WB_ACK  = 1'b1;
  localparam logic WB_NACK = 1'b0;

  // Register responder map (offsets within its 0x3xxx_xxxx window)
  localparam logic [7:0]           REG_ID_OFS = 8'h04;
  localparam logic [7:0]           REG_WR_OFS = 8'h18;
  localparam logic [7:0]           REG_RD_OFS = 8'h1C;
  localparam logic [WB_DATA_W-1:0] REG_ID_VAL = 32'h4669_626F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_initiator_if.sv
// Command/response handshake plus Wishbone classic master bus, bundled so the
// initiator and whoever drives it share one set of signal definitions.
interface wb_initiator_if
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [WB_SEL_W-1:0]   cmd_sel;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WB_DATA_W-1:0]  cmd_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WB_DATA_W-1:0]  rsp_data;
  logic                  rsp_err;

  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [WB_SEL_W-1:0]   wbm_sel_o;
  logic [ADDR_WIDTH-1:0] wbm_adr_o;
  logic [WB_DATA_W-1:0]  wbm_dat_o;
  logic                  wbm_ack_i;
  logic [WB_DATA_W-1:0]  wbm_dat_i;

  logic [CNT_W-1:0]      txn_count;
  logic [CNT_W-1:0]      err_count;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_data, rsp_ready,
           wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
           txn_count, err_count
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_data, rsp_ready,
           wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
           txn_count, err_count
  );

endinterface

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle whose count would reach the limit.
module wb_watchdog
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [WDOG_W-1:0] i_limit,
  output logic              o_expired
);

  logic [WDOG_W-1:0] r_cnt;
  logic [WDOG_W:0]   w_next;

  assign w_next    = {1'b0, r_cnt} + 1'b1;
  // Expiry is announced on the edge that would make the count reach the limit
  assign o_expired = i_enable && (w_next >= {1'b0, i_limit});

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= w_next[WDOG_W-1:0];
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: accepts one command, runs one
// bus cycle (ack or timeout), then holds the response until it is consumed.
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_initiator_if.master   bus
);

  localparam logic [WDOG_W-1:0] TO_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  wb_state_e r_state, w_state_nxt;

  logic                  r_we;
  logic [WB_SEL_W-1:0]   r_sel;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [WB_DATA_W-1:0]  r_dat;
  logic [WB_DATA_W-1:0]  r_rsp_data;
  logic                  r_rsp_err;
  logic [CNT_W-1:0]      r_txn;
  logic [CNT_W-1:0]      r_err;

  logic w_cyc;
  logic w_ack;
  logic w_accept;
  logic w_done_ack;
  logic w_done_to;
  logic w_expired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign w_cyc = (r_state == ST_BUS);
  assign w_ack = (bus.wbm_ack_i == WB_ACK);

  wb_watchdog u_wdog (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .i_clear   (r_state != ST_BUS),
    .i_enable  (w_cyc && !w_ack),
    .i_limit   (TO_LIMIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ack is tested before expiry so a same-edge ack always wins
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_ack  = 1'b0;
    w_done_to   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (w_ack) begin
          w_done_ack  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_expired) begin
          w_done_to   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_txn      <= '0;
      r_err      <= '0;
    end else begin
      if (w_accept) begin
        r_we  <= bus.cmd_we;
        r_sel <= bus.cmd_sel;
        r_adr <= bus.cmd_addr;
        r_dat <= bus.cmd_data;
      end
      if (w_done_ack) begin
        r_rsp_data <= bus.wbm_dat_i;
        r_rsp_err  <= 1'b0;
      end else if (w_done_to) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
      if (w_done_ack || w_done_to) begin
        r_txn <= sat_inc(r_txn);
      end
      if (w_done_to) begin
        r_err <= sat_inc(r_err);
      end
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  // Bus qualifiers are forced low outside a cycle so the bus idles at zero
  assign bus.wbm_cyc_o = w_cyc;
  assign bus.wbm_stb_o = w_cyc;
  assign bus.wbm_we_o  = w_cyc ? r_we  : 1'b0;
  assign bus.wbm_sel_o = w_cyc ? r_sel : '0;
  assign bus.wbm_adr_o = w_cyc ? r_adr : '0;
  assign bus.wbm_dat_o = w_cyc ? r_dat : '0;

  assign bus.txn_count = r_txn;
  assign bus.err_count = r_err;

endmodule
